// File: rtl/ring_pos_remote_wrr_arbiter_pkg.sv
// Shared types and sizing for the ring position-to-remote arbitration path.
package ring_pos_remote_wrr_arbiter_pkg;

   localparam int NUM_REMOTE_DEST_NODES = 4;
   localparam int REMOTE_NODE_IDX_WIDTH = $clog2(NUM_REMOTE_DEST_NODES);
   localparam int WRR_WEIGHT_WIDTH      = 4;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ring_pos_remote_wrr_arbiter_rr_pick.sv
// Circular priority select: first set bit of req scanning ptr, ptr+1, ...
// wrapping modulo NUM_REQ (not modulo 2^IDX_W). ptr must be < NUM_REQ.
module ring_pos_remote_wrr_arbiter_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   // Scan every candidate in rotation order and keep the first requester.
   always_comb begin : scan
      int         pos_i;
      logic [IDX_W-1:0] pos;
      found = 1'b0;
      idx   = '0;
      pos_i = 0;
      pos   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos_i = int'(ptr) + i;
         if (pos_i >= NUM_REQ) pos_i = pos_i - NUM_REQ;
         pos = IDX_W'(pos_i);
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/ring_pos_remote_wrr_arbiter.sv
// Weighted round-robin arbiter with packet lock onto one remote link.
// Handshake: a beat transfers (o_beat_fire) when the link is granted
// (o_grant_valid), the owner presents data (i_request[owner]) and the
// downstream accepts (i_ready); neither side may make its signal depend on
// the other's. A packet ends on a fired beat with i_last[owner] set.
module ring_pos_remote_wrr_arbiter
   import ring_pos_remote_wrr_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REMOTE_DEST_NODES,
   parameter int IDX_W    = $clog2(NUM_REQ),
   parameter int WEIGHT_W = WRR_WEIGHT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_arbiter_en,
   input  logic [NUM_REQ-1:0]          i_request,
   input  logic [NUM_REQ-1:0]          i_last,
   input  logic [NUM_REQ*WEIGHT_W-1:0] i_weight,
   input  logic                        i_ready,
   output logic [NUM_REQ-1:0]          o_grant,
   output logic [IDX_W-1:0]            o_grant_idx,
   output logic                        o_grant_valid,
   output logic                        o_beat_fire,
   output arb_state_t                  o_state
);

   arb_state_t          state, state_n;
   logic [IDX_W-1:0]    owner, owner_n;
   logic [IDX_W-1:0]    ptr, ptr_n;
   logic [WEIGHT_W-1:0] pkt_cnt, pkt_cnt_n;
   logic                mid_pkt, mid_pkt_n;

   logic                owner_req, owner_last, beat_fire, pkt_end, release_now;
   logic [IDX_W-1:0]    owner_inc, pick_ptr, pick_idx;
   logic                pick_found;
   logic [WEIGHT_W-1:0] wt_raw, load_wt;

   assign owner_req  = i_request[owner];
   assign owner_last = i_last[owner];
   assign beat_fire  = o_grant_valid & owner_req & i_ready;
   assign pkt_end    = beat_fire & owner_last;
   assign owner_inc  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

   // Release on the last packet of the quota, on a packet end with the
   // arbiter disabled, or at a packet boundary when the owner has gone quiet
   // or the arbiter is disabled. Never releases in the middle of a packet.
   assign release_now = (state == ARB_GRANT) &&
                        ((pkt_end && ((pkt_cnt <= WEIGHT_W'(1)) || !i_arbiter_en)) ||
                         (!mid_pkt && !beat_fire && (!owner_req || !i_arbiter_en)));

   // On release the search starts just past the old owner, so the winner of
   // a same-cycle re-arbitration already reflects the rotated pointer.
   assign pick_ptr = release_now ? owner_inc : ptr;

   ring_pos_remote_wrr_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (i_request),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Fetch the winner's weight; zero is promoted to one packet.
   always_comb begin
      wt_raw = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_idx == IDX_W'(k)) wt_raw = i_weight[k*WEIGHT_W +: WEIGHT_W];
      end
      load_wt = (wt_raw == '0) ? WEIGHT_W'(1) : wt_raw;
   end

   // Next-state logic for grant ownership, rotation pointer and quota.
   always_comb begin
      state_n   = state;
      owner_n   = owner;
      ptr_n     = ptr;
      pkt_cnt_n = pkt_cnt;
      mid_pkt_n = mid_pkt;
      case (state)
         ARB_IDLE: begin
            if (i_arbiter_en && pick_found) begin
               state_n   = ARB_GRANT;
               owner_n   = pick_idx;
               pkt_cnt_n = load_wt;
               mid_pkt_n = 1'b0;
            end
         end
         ARB_GRANT: begin
            if (release_now) begin
               ptr_n     = owner_inc;
               mid_pkt_n = 1'b0;
               if (i_arbiter_en && pick_found) begin
                  owner_n   = pick_idx;
                  pkt_cnt_n = load_wt;
               end else begin
                  state_n   = ARB_IDLE;
                  owner_n   = '0;
                  pkt_cnt_n = '0;
               end
            end else if (pkt_end) begin
               pkt_cnt_n = pkt_cnt - WEIGHT_W'(1);
               mid_pkt_n = 1'b0;
            end else if (beat_fire) begin
               mid_pkt_n = 1'b1;
            end
         end
         default: state_n = ARB_IDLE;
      endcase
   end

   // State and registered grant outputs, all derived from next-state values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ARB_IDLE;
         owner         <= '0;
         ptr           <= '0;
         pkt_cnt       <= '0;
         mid_pkt       <= 1'b0;
         o_grant       <= '0;
         o_grant_idx   <= '0;
         o_grant_valid <= 1'b0;
      end else begin
         state         <= state_n;
         owner         <= owner_n;
         ptr           <= ptr_n;
         pkt_cnt       <= pkt_cnt_n;
         mid_pkt       <= mid_pkt_n;
         o_grant_valid <= (state_n == ARB_GRANT);
         o_grant_idx   <= (state_n == ARB_GRANT) ? owner_n : '0;
         o_grant       <= (state_n == ARB_GRANT) ? (NUM_REQ'(1) << owner_n) : '0;
      end
   end

   assign o_beat_fire = beat_fire;
   assign o_state     = state;

endmodule

// File: tb/tb_ring_pos_remote_wrr_arbiter.sv
// Directed bench for the weighted round-robin ring arbiter (4 and 3 requesters).
module tb_ring_pos_remote_wrr_arbiter;
   import ring_pos_remote_wrr_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int WW = 4;
   localparam int N3 = 3;

   // Clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 4-requester instance
   logic          en4, rdy4, fire4, v4;
   logic [N-1:0]  req4, last4, g4;
   logic [N*WW-1:0] w4;
   logic [IW-1:0] idx4;
   arb_state_t    st4;

   // 3-requester instance
   logic          en3, rdy3, fire3, v3;
   logic [N3-1:0] req3, last3, g3;
   logic [N3*WW-1:0] w3;
   logic [IW-1:0] idx3;
   arb_state_t    st3;

   ring_pos_remote_wrr_arbiter #(.NUM_REQ(N), .IDX_W(IW), .WEIGHT_W(WW)) dut (
      .clk(clk), .rst(rst), .i_arbiter_en(en4), .i_request(req4), .i_last(last4),
      .i_weight(w4), .i_ready(rdy4), .o_grant(g4), .o_grant_idx(idx4),
      .o_grant_valid(v4), .o_beat_fire(fire4), .o_state(st4)
   );

   ring_pos_remote_wrr_arbiter #(.NUM_REQ(N3), .IDX_W(IW), .WEIGHT_W(WW)) dut3 (
      .clk(clk), .rst(rst), .i_arbiter_en(en3), .i_request(req3), .i_last(last3),
      .i_weight(w3), .i_ready(rdy3), .o_grant(g3), .o_grant_idx(idx3),
      .o_grant_valid(v3), .o_beat_fire(fire3), .o_state(st3)
   );

   // Scoreboard
   int n_cmp = 0;
   int n_bad = 0;
   logic [IW-1:0] exp_q[$];
   logic [IW-1:0] mon_e;
   logic [N-1:0]  mon_oh;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive4(input logic en, input logic [N-1:0] req, input logic [N-1:0] last,
                         input logic rdy);
      en4 = en; req4 = req; last4 = last; rdy4 = rdy;
   endtask

   task automatic drive3(input logic en, input logic [N3-1:0] req, input logic [N3-1:0] last,
                         input logic rdy);
      en3 = en; req3 = req; last3 = last; rdy3 = rdy;
   endtask

   task automatic push(input int idx);
      exp_q.push_back(IW'(idx));
   endtask

   task automatic chk_idle4(input string name);
      chk({name, "_grant"}, 32'(g4), 0);
      chk({name, "_valid"}, 32'(v4), 0);
      chk({name, "_state"}, 32'(st4), 32'(ARB_IDLE));
   endtask

   // Monitor: every fired beat must match the next expected owner
   always @(negedge clk) begin
      if (!rst && fire4) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got owner %0d expected no beat", idx4);
         end else begin
            mon_e  = exp_q.pop_front();
            mon_oh = N'(1) << mon_e;
            chk("beat_owner", 32'(idx4), 32'(mon_e));
            chk("beat_grant", 32'(g4), 32'(mon_oh));
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive4(1'b0, '0, '0, 1'b0);
      drive3(1'b0, '0, '0, 1'b0);
      w4 = 16'h1111;
      w3 = 12'h111;
      tick(2);
      // Reset state
      chk_idle4("reset");
      chk("reset_idx", 32'(idx4), 0);
      chk("reset_fire", 32'(fire4), 0);
      chk("reset_grant3", 32'(g3), 0);
      rst = 1'b0;
      tick(1);

      // 1: all request, single-beat packets, rotation with no bubbles
      drive4(1'b1, 4'b1111, 4'b1111, 1'b1);
      push(0); push(1); push(2); push(3); push(0);
      tick(6);
      drive4(1'b1, 4'b0000, 4'b1111, 1'b1);
      tick(1);
      chk("rot_drained", 32'(exp_q.size()), 0);
      chk_idle4("rot_end");

      // 2: requester 2 sends 3 beats, requester 0 joins after beat 1
      drive4(1'b1, 4'b0100, 4'b0000, 1'b1);
      push(2); push(2); push(2); push(0);
      tick(2);
      drive4(1'b1, 4'b0101, 4'b0000, 1'b1);
      tick(1);
      chk("lock_grant", 32'(g4), 32'(4'b0100));
      drive4(1'b1, 4'b0101, 4'b0100, 1'b1);
      tick(1);
      chk("lock_handover", 32'(g4), 32'(4'b0001));
      drive4(1'b1, 4'b0001, 4'b0001, 1'b1);
      tick(1);
      drive4(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick(1);
      chk("lock_drained", 32'(exp_q.size()), 0);
      chk_idle4("lock_end");

      // 3: weight[1]=3, requesters 0 and 1, single-beat packets
      w4 = 16'h1131;
      drive4(1'b1, 4'b0011, 4'b1111, 1'b1);
      push(1); push(1); push(1); push(0); push(1); push(1); push(1); push(0);
      tick(9);
      drive4(1'b1, 4'b0000, 4'b1111, 1'b1);
      tick(1);
      w4 = 16'h1111;
      chk("wrr_drained", 32'(exp_q.size()), 0);
      chk_idle4("wrr_end");

      // 4: stall with ready low and owner request dropping mid-packet
      drive4(1'b1, 4'b0001, 4'b0000, 1'b1);
      push(0); push(0);
      tick(2);
      for (int i = 0; i < 5; i++) begin
         drive4(1'b1, (i < 2) ? 4'b0000 : 4'b0001, 4'b0000, 1'b0);
         #1;
         chk("stall_grant", 32'(g4), 32'(4'b0001));
         chk("stall_fire", 32'(fire4), 0);
         tick(1);
      end
      drive4(1'b1, 4'b0001, 4'b0001, 1'b1);
      tick(1);
      drive4(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick(1);
      chk("stall_drained", 32'(exp_q.size()), 0);
      chk_idle4("stall_end");

      // 5: disable mid-packet; packet completes, then stays idle
      drive4(1'b1, 4'b1010, 4'b0000, 1'b1);
      push(1); push(1); push(1);
      tick(2);
      drive4(1'b0, 4'b1010, 4'b0000, 1'b1);
      tick(1);
      drive4(1'b0, 4'b1010, 4'b1010, 1'b1);
      tick(1);
      drive4(1'b0, 4'b1010, 4'b0000, 1'b1);
      chk_idle4("dis_release");
      tick(2);
      chk_idle4("dis_hold");
      chk("dis_drained", 32'(exp_q.size()), 0);
      push(3);
      drive4(1'b1, 4'b1010, 4'b1010, 1'b1);
      tick(1);
      chk("reen_grant", 32'(g4), 32'(4'b1000));
      tick(1);
      drive4(1'b1, 4'b0000, 4'b0000, 1'b1);
      tick(1);
      chk("reen_drained", 32'(exp_q.size()), 0);
      chk_idle4("reen_end");

      // 6: three requesters, modulo-3 wrap, then reset mid-packet
      drive3(1'b1, 3'b010, 3'b111, 1'b1);
      tick(1);
      chk("n3_first", 32'(g3), 32'(3'b010));
      chk("n3_first_idx", 32'(idx3), 1);
      chk("n3_first_fire", 32'(fire3), 1);
      tick(1);
      chk("n3_wrap", 32'(g3), 32'(3'b010));
      drive3(1'b1, 3'b100, 3'b111, 1'b1);
      tick(1);
      chk("n3_to2", 32'(g3), 32'(3'b100));
      drive3(1'b1, 3'b101, 3'b111, 1'b1);
      tick(1);
      chk("n3_ptr_wrap0", 32'(g3), 32'(3'b001));
      drive3(1'b1, 3'b011, 3'b001, 1'b1);
      tick(1);
      chk("n3_to1", 32'(g3), 32'(3'b010));
      drive3(1'b1, 3'b011, 3'b000, 1'b1);
      tick(1);
      chk("n3_midpkt", 32'(g3), 32'(3'b010));
      rst = 1'b1;
      tick(1);
      chk("n3_rst_grant", 32'(g3), 0);
      chk("n3_rst_idx", 32'(idx3), 0);
      chk("n3_rst_valid", 32'(v3), 0);
      chk("n3_rst_state", 32'(st3), 32'(ARB_IDLE));
      chk("n3_rst_fire", 32'(fire3), 0);
      rst = 1'b0;
      tick(1);
      chk("n3_rst_ptr0", 32'(g3), 32'(3'b001));
      drive3(1'b0, '0, '0, 1'b0);
      tick(2);

      chk("final_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
